// File: rtl/iic_target_pkg.sv
// Shared types and constants for the I2C target register window.
package iic_target_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  // Shift one received bit into a byte, MSB first.
  function automatic logic [BYTE_BITS-1:0] shift_in(input logic [BYTE_BITS-1:0] cur,
                                                    input logic bit_in);
    return {cur[BYTE_BITS-2:0], bit_in};
  endfunction

endpackage

// File: rtl/iic_target_regfile_if.sv
// I2C pad signals plus the register-window port of the target.
interface iic_target_regfile_if
  import iic_target_pkg::*;
#(
  parameter int unsigned PTR_W = 4
);

  logic                 SCL_I;
  logic                 SDA_I;
  logic                 SDA_O;
  logic                 SDA_T;
  logic [PTR_W-1:0]     REG_ADDR;
  logic [BYTE_BITS-1:0] REG_WDATA;
  logic                 REG_WE;
  logic                 REG_RE;
  logic [BYTE_BITS-1:0] REG_RDATA;
  logic                 BUSY;

  modport slave (
    input  SCL_I, SDA_I, REG_RDATA,
    output SDA_O, SDA_T, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );

  modport master (
    output SCL_I, SDA_I, REG_RDATA,
    input  SDA_O, SDA_T, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );

endinterface

// File: rtl/iic_line_filter.sv
// Two-flop synchroniser, run-length glitch filter and edge pulses for one I2C line.
module iic_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iic_target_regfile.sv
// I2C target exposing an auto-incrementing register window (EEPROM-style pointer).
module iic_target_regfile
  import iic_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned PTR_W      = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  iic_target_regfile_if.slave  bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (bus.SCL_I),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (bus.SDA_I),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_e               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BYTE_BITS-1:0] shreg;
  logic [BYTE_BITS-1:0] wdata;
  logic [PTR_W-1:0]     ptr;
  logic                 rw;
  logic                 ack_on;
  logic                 sda_t;
  logic                 reg_we;
  logic                 reg_re;
  logic                 rd_pend;
  logic                 busy;

  logic                 start_c;
  logic                 stop_c;
  logic                 last_bit_c;
  logic                 addr_hit_c;
  logic [BYTE_BITS-1:0] byte_c;

  assign start_c    = sda_fall & scl_lvl;
  assign stop_c     = sda_rise & scl_lvl;
  assign byte_c     = shift_in(shreg, sda_lvl);
  assign last_bit_c = (bit_cnt == CNT_W'(BYTE_BITS - 1));
  assign addr_hit_c = (byte_c[BYTE_BITS-1:1] == DEV_ADDR) && (DEV_ADDR != 7'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wdata   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_on  <= 1'b0;
      sda_t   <= 1'b1;
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_pend <= 1'b0;
      busy    <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_pend <= reg_re;

      // Post-access pointer bump; runs even if STOP lands right after the strobe.
      if (reg_we) begin
        ptr <= ptr + PTR_W'(1);
      end
      if (rd_pend) begin
        shreg <= bus.REG_RDATA;
        ptr   <= ptr + PTR_W'(1);
      end

      if (stop_c) begin
        state   <= IDLE;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
      end else if (start_c) begin
        state   <= ADDR;
        sda_t   <= 1'b1;
        busy    <= 1'b1;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_t <= 1'b1;
          end

          ADDR: begin
            if (scl_rise) begin
              shreg <= byte_c;
              if (last_bit_c) begin
                bit_cnt <= '0;
                if (addr_hit_c) begin
                  state  <= ADDR_ACK;
                  rw     <= sda_lvl;
                  reg_re <= sda_lvl;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          // First fall starts the ACK, second fall ends it.
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_t  <= ACK;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                if (state == WR_ACK) begin
                  sda_t <= 1'b1;
                  state <= WR_DATA;
                end else if (rw) begin
                  sda_t   <= shreg[BYTE_BITS-1];
                  shreg   <= shift_in(shreg, 1'b0);
                  bit_cnt <= CNT_W'(1);
                  state   <= RD_DATA;
                end else begin
                  sda_t <= 1'b1;
                  state <= WR_PTR;
                end
              end
            end
          end

          WR_PTR, WR_DATA: begin
            if (scl_rise) begin
              shreg <= byte_c;
              if (last_bit_c) begin
                bit_cnt <= '0;
                state   <= WR_ACK;
                if (state == WR_PTR) begin
                  ptr <= byte_c[PTR_W-1:0];
                end else begin
                  reg_we <= 1'b1;
                  wdata  <= byte_c;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          // bit_cnt counts bits already placed on the line.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == CNT_W'(BYTE_BITS)) begin
                sda_t   <= 1'b1;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_t   <= shreg[BYTE_BITS-1];
                shreg   <= shift_in(shreg, 1'b0);
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK) begin
                reg_re <= 1'b1;
                state  <= RD_DATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: begin
            sda_t <= 1'b1;
          end

          default: begin
            state <= IDLE;
            sda_t <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.SDA_O     = 1'b0;
  assign bus.SDA_T     = sda_t;
  assign bus.REG_ADDR  = ptr;
  assign bus.REG_WDATA = wdata;
  assign bus.REG_WE    = reg_we;
  assign bus.REG_RE    = reg_re;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_iic_target_regfile.sv
// Bit-banged I2C controller driving the target, checked against a register-window model.
module tb_iic_target_regfile;

  localparam int unsigned PTR_W = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned Q     = 10;

  logic clk;
  logic rst_n;
  logic scl;
  logic sda;
  logic [7:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  iic_target_regfile_if #(.PTR_W(PTR_W)) bus ();

  iic_target_regfile #(
    .DEV_ADDR   (7'h50),
    .FILTER_LEN (3),
    .PTR_W      (PTR_W)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  assign bus.SCL_I     = scl;
  assign bus.SDA_I     = sda & (bus.SDA_T | bus.SDA_O);
  assign bus.REG_RDATA = rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board-side register storage plus transaction logs.
  logic [7:0]       regs [DEPTH];
  logic [PTR_W+7:0] we_q [$];
  logic [PTR_W-1:0] re_q [$];
  int               sda_low_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'(i) ^ 8'hFF;
      rdata <= 8'h00;
    end else begin
      if (bus.REG_WE) begin
        regs[bus.REG_ADDR] <= bus.REG_WDATA;
        we_q.push_back({bus.REG_ADDR, bus.REG_WDATA});
      end
      if (bus.REG_RE) begin
        rdata <= regs[bus.REG_ADDR];
        re_q.push_back(bus.REG_ADDR);
      end
      if (bus.SDA_T == 1'b0) sda_low_cnt <= sda_low_cnt + 1;
    end
  end

  // Reference model of the register window.
  logic [7:0] model_mem [DEPTH];
  int         model_ptr;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i) ^ 8'hFF;
    model_ptr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda = 1'b1; wclk(Q);
    scl = 1'b1; wclk(Q);
    sda = 1'b0; wclk(Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; wclk(Q);
    scl = 1'b1; wclk(Q);
    sda = 1'b1; wclk(2 * Q);
  endtask

  // One SCL period; optional SDA spike and short SCL dropout while SCL is high.
  task automatic bit_tx(input logic b, input logic glitch, output logic r);
    sda = b; wclk(Q);
    scl = 1'b1; wclk(Q / 2);
    r = bus.SDA_I;
    if (glitch) begin
      sda = ~b;   wclk(1);
      sda = b;    wclk(2);
      scl = 1'b0; wclk(2);
      scl = 1'b1; wclk(Q / 2 + Q - 5);
    end else begin
      wclk(Q / 2 + Q);
    end
    scl = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_tx(d[i], glitch, r);
    bit_tx(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic ack_val, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_tx(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    bit_tx(ack_val, 1'b0, r);
  endtask

  logic             ack;
  logic             r;
  logic [7:0]       d;
  int               p, n, we_base, re_base, low_base;
  logic [PTR_W+7:0] exp_we [4];

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    scl   = 1'b1;
    sda   = 1'b1;
    model_reset();
    wclk(5);
    chk("reset_sda_t",  32'(bus.SDA_T), 32'd1);
    chk("reset_sda_o",  32'(bus.SDA_O), 32'd0);
    chk("reset_we",     32'(bus.REG_WE), 32'd0);
    chk("reset_re",     32'(bus.REG_RE), 32'd0);
    chk("reset_busy",   32'(bus.BUSY), 32'd0);
    chk("reset_addr",   32'(bus.REG_ADDR), 32'd0);
    rst_n = 1'b1;
    wclk(10);

    // Pointer 3, two data bytes.
    we_base = we_q.size();
    i2c_start();
    send_byte(8'hA0, 1'b0, ack); chk("wr_addr_ack", 32'(ack), 32'd0);
    chk("wr_busy", 32'(bus.BUSY), 32'd1);
    send_byte(8'h03, 1'b0, ack); chk("wr_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'hA5, 1'b0, ack); chk("wr_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, 1'b0, ack); chk("wr_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    model_mem[3] = 8'hA5; model_mem[4] = 8'h5A; model_ptr = 5;
    chk("wr_we_count", 32'(we_q.size() - we_base), 32'd2);
    chk("wr_we0", 32'(we_q[we_base]),     32'({4'h3, 8'hA5}));
    chk("wr_we1", 32'(we_q[we_base + 1]), 32'({4'h4, 8'h5A}));
    chk("wr_ptr_final", 32'(bus.REG_ADDR), 32'(model_ptr));
    chk("wr_busy_end",  32'(bus.BUSY), 32'd0);

    // Pointer write, repeated START, 3-byte read wrapping past 0xF.
    re_base = re_q.size();
    i2c_start();
    send_byte(8'hA0, 1'b0, ack); chk("rd_waddr_ack", 32'(ack), 32'd0);
    send_byte(8'h0E, 1'b0, ack); chk("rd_wptr_ack",  32'(ack), 32'd0);
    i2c_start();
    send_byte(8'hA1, 1'b0, ack); chk("rd_raddr_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 3; k++) begin
      recv_byte((k == 2) ? 1'b1 : 1'b0, d);
      chk($sformatf("rd_byte%0d", k), 32'(d), 32'(model_mem[(14 + k) % DEPTH]));
    end
    chk("rd_nack_release", 32'(bus.SDA_T), 32'd1);
    bit_tx(1'b1, 1'b0, r);
    chk("rd_wait_stop_line", 32'(r), 32'd1);
    i2c_stop();
    model_ptr = (14 + 3) % DEPTH;
    chk("rd_re_count", 32'(re_q.size() - re_base), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rd_re_addr%0d", k), 32'(re_q[re_base + k]), 32'((14 + k) % DEPTH));
    chk("rd_ptr_final", 32'(bus.REG_ADDR), 32'(model_ptr));

    // Foreign address 0x51: never pulls SDA, no register traffic.
    we_base = we_q.size(); re_base = re_q.size(); low_base = sda_low_cnt;
    i2c_start();
    send_byte(8'hA2, 1'b0, ack); chk("na_addr_nack", 32'(ack), 32'd1);
    send_byte(8'h33, 1'b0, ack); chk("na_data_nack", 32'(ack), 32'd1);
    chk("na_busy", 32'(bus.BUSY), 32'd1);
    i2c_stop();
    chk("na_sda_low", 32'(sda_low_cnt - low_base), 32'd0);
    chk("na_we", 32'(we_q.size() - we_base), 32'd0);
    chk("na_re", 32'(re_q.size() - re_base), 32'd0);
    chk("na_busy_end", 32'(bus.BUSY), 32'd0);
    chk("na_ptr", 32'(bus.REG_ADDR), 32'(model_ptr));

    // Glitches on both lines while SCL is high must be invisible.
    we_base = we_q.size();
    i2c_start();
    send_byte(8'hA0, 1'b1, ack); chk("gl_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h07, 1'b1, ack); chk("gl_ptr_ack",  32'(ack), 32'd0);
    send_byte(8'h3C, 1'b1, ack); chk("gl_data_ack", 32'(ack), 32'd0);
    chk("gl_busy", 32'(bus.BUSY), 32'd1);
    i2c_stop();
    model_mem[7] = 8'h3C; model_ptr = 8;
    chk("gl_we_count", 32'(we_q.size() - we_base), 32'd1);
    chk("gl_we0", 32'(we_q[we_base]), 32'({4'h7, 8'h3C}));
    chk("gl_ptr", 32'(bus.REG_ADDR), 32'(model_ptr));

    // STOP after 5 bits of a data byte discards it.
    we_base = we_q.size();
    i2c_start();
    send_byte(8'hA0, 1'b0, ack); chk("pt_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h02, 1'b0, ack); chk("pt_ptr_ack",  32'(ack), 32'd0);
    for (int i = 0; i < 5; i++) bit_tx(1'b1, 1'b0, r);
    i2c_stop();
    model_ptr = 2;
    chk("pt_we", 32'(we_q.size() - we_base), 32'd0);
    chk("pt_ptr", 32'(bus.REG_ADDR), 32'(model_ptr));
    chk("pt_busy", 32'(bus.BUSY), 32'd0);

    // Asynchronous reset while the address ACK is on the line.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_tx(((8'hA0 >> i) & 8'h01) != 8'h00, 1'b0, r);
    begin : wait_ack
      int t;
      t = 0;
      while (bus.SDA_T !== 1'b0 && t < 50) begin
        wclk(1);
        t++;
      end
    end
    chk("rs_ack_driven", 32'(bus.SDA_T), 32'd0);
    #3 rst_n = 1'b0;
    #1 chk("rs_async_release", 32'(bus.SDA_T), 32'd1);
    scl = 1'b1;
    sda = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    model_reset();
    wclk(10);
    chk("rs_ptr", 32'(bus.REG_ADDR), 32'd0);
    chk("rs_busy", 32'(bus.BUSY), 32'd0);

    // Random write-then-readback transactions against the model.
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 3);
      we_base = we_q.size();
      i2c_start();
      send_byte(8'hA0, 1'b0, ack); chk($sformatf("rnd%0d_waddr_ack", it), 32'(ack), 32'd0);
      send_byte({4'($urandom_range(0, 15)), 4'(p)}, 1'b0, ack);
      chk($sformatf("rnd%0d_wptr_ack", it), 32'(ack), 32'd0);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send_byte(d, 1'b0, ack);
        chk($sformatf("rnd%0d_wd%0d_ack", it, k), 32'(ack), 32'd0);
        model_mem[(p + k) % DEPTH] = d;
        exp_we[k] = {4'((p + k) % DEPTH), d};
      end
      i2c_stop();
      model_ptr = (p + n) % DEPTH;
      chk($sformatf("rnd%0d_we_count", it), 32'(we_q.size() - we_base), 32'(n));
      for (int k = 0; k < n; k++)
        chk($sformatf("rnd%0d_we%0d", it, k), 32'(we_q[we_base + k]), 32'(exp_we[k]));
      chk($sformatf("rnd%0d_wptr_end", it), 32'(bus.REG_ADDR), 32'(model_ptr));

      re_base = re_q.size();
      i2c_start();
      send_byte(8'hA0, 1'b0, ack); chk($sformatf("rnd%0d_raddr0_ack", it), 32'(ack), 32'd0);
      send_byte(8'(p), 1'b0, ack); chk($sformatf("rnd%0d_rptr_ack", it), 32'(ack), 32'd0);
      i2c_start();
      send_byte(8'hA1, 1'b0, ack); chk($sformatf("rnd%0d_raddr1_ack", it), 32'(ack), 32'd0);
      for (int k = 0; k < n; k++) begin
        recv_byte((k == n - 1) ? 1'b1 : 1'b0, d);
        chk($sformatf("rnd%0d_rd%0d", it, k), 32'(d), 32'(model_mem[(p + k) % DEPTH]));
      end
      i2c_stop();
      chk($sformatf("rnd%0d_re_count", it), 32'(re_q.size() - re_base), 32'(n));
      chk($sformatf("rnd%0d_rptr_end", it), 32'(bus.REG_ADDR), 32'(model_ptr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_target_regfile.md
Name: iic_target_regfile

Overview:
- I2C target (responder) for the IIC_MAIN bus: the opposite end of the AXI IIC controller already in the design.
- Gives a board-side register window (EEPROM-style pointer plus auto-increment) to an external I2C controller, or to our own controller in loopback BIST.
- Connects to an IOBUF through SDA_O/SDA_T. SCL is input-only; the block never stretches the clock.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address that this block responds to.
- FILTER_LEN, 3, number of consecutive identical CLK samples needed before a filtered line level changes.
- PTR_W, 4, register pointer width; the window holds 2**PTR_W bytes.

Ports:
- CLK, input, 1, system clock; must be at least 20x the SCL rate.
- RESET_N, input, 1, asynchronous active-low reset.
- SCL_I, input, 1, SCL pad input.
- SDA_I, input, 1, SDA pad input.
- SDA_O, output, 1, SDA drive value; constant 0 (open-drain).
- SDA_T, output, 1, SDA tristate: 1 = release the line, 0 = pull it low.
- REG_ADDR, output, PTR_W, current register pointer.
- REG_WDATA, output, 8, write data; valid while REG_WE is high.
- REG_WE, output, 1, one-cycle write strobe.
- REG_RE, output, 1, one-cycle read request.
- REG_RDATA, input, 8, read data; must be valid one CLK after REG_RE.
- BUSY, output, 1, high from START until STOP.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - SDA_T=1, SDA_O=0, REG_WE=0, REG_RE=0, BUSY=0, REG_ADDR=0.
  - State=IDLE, filters preset to 1.
  - Reset asserted mid-transfer releases SDA immediately.
- Line conditioning, per line:
  - 2-FF synchroniser, then glitch filter: the filtered value changes only after FILTER_LEN consecutive equal samples.
  - Edge pulses come from the filtered SCL.
- Bus conditions:
  - START = filtered SDA falls while filtered SCL=1.
  - STOP = filtered SDA rises while filtered SCL=1.
  - Both are checked every cycle and take priority over bit processing.
- Bit timing:
  - Data is sampled on SCL rise.
  - SDA_T changes only on SCL fall.
  - MSB first.
- States:
  - IDLE: START -> ADDR, BUSY=1.
  - ADDR: shift 8 bits.
    - On the 8th rise, if addr==DEV_ADDR: ADDR_ACK.
    - Else: WAIT_STOP (SDA_T stays 1).
    - If R/W=1, also pulse REG_RE with REG_ADDR=ptr.
  - ADDR_ACK:
    - SDA_T=0 from the next SCL fall until the following SCL fall.
    - Then go to RD_DATA if R/W=1, else WR_PTR.
  - WR_PTR:
    - On the 8th rise, ptr <= byte[PTR_W-1:0]; upper bits are ignored.
    - Then WR_ACK, next data state WR_DATA.
  - WR_DATA:
    - On the 8th rise, REG_WE=1 for one cycle with REG_ADDR=ptr and REG_WDATA=byte.
    - The next cycle ptr <= ptr+1.
    - Then WR_ACK.
  - WR_ACK: drive ACK as in ADDR_ACK, then return to WR_DATA.
  - RD_DATA:
    - REG_RDATA is captured into the shift register the cycle after REG_RE, and ptr <= ptr+1 in the same cycle.
    - Bit 7 is driven starting at the SCL fall that ends the ACK. A bit of value 1 gives SDA_T=1; a bit of value 0 gives SDA_T=0.
    - After the 8th bit, at SCL fall, SDA_T=1 and go to RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK): pulse REG_RE, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA_T=1; ignore bits.
- Repeated START in any non-IDLE state:
  - Go to ADDR, SDA_T=1, bit counter cleared.
  - ptr is kept, so write-pointer-then-read works.
- STOP in any state:
  - Go to IDLE, SDA_T=1, BUSY=0.
  - A partially received byte is discarded with no REG_WE.
- Pointer arithmetic: ptr wraps modulo 2**PTR_W (0xF+1 -> 0x0 at PTR_W=4).
- Simultaneous events: if a write strobe and STOP coincide, the strobe completes, because it was issued on the 8th rise, before the STOP.
- General call (address 0) is not acknowledged; no 10-bit addressing.

Decomposition:
- Package iic_target_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP);
  - ACK=1'b0 and NACK=1'b1;
  - BYTE_BITS=8.
- One sub-module, iic_line_filter: synchroniser, FILTER_LEN glitch filter and rise/fall pulses. It is instantiated for SCL and for SDA.

Test Plan:
- START, 0xA0, 0x03, 0xA5, 0x5A, STOP -> three ACKs plus ACK of the final byte; REG_WE at REG_ADDR 3 with 0xA5, then at 4 with 0x5A; final ptr=5.
- Pointer write 0x0E, repeated START, address 0xA1, REG_RDATA model mem[i]=i^0xFF; read 3 bytes, controller ACK, ACK, NACK -> bytes 0xF1, 0xF0, 0xFF; REG_RE at addresses E, F, 0 (wrap); SDA released after the NACK.
- START, 0xA2 (address 0x51) -> SDA_T=1 for the whole transaction, no REG_WE/REG_RE, BUSY drops at STOP.
- Single-CLK SDA pulses while SCL high, plus 2-cycle SCL glitches mid-byte (FILTER_LEN=3) -> no START/STOP detected, bit count unchanged, data intact.
- STOP after 5 bits of a data byte -> IDLE, no REG_WE, ptr unchanged.
- RESET_N low during ADDR_ACK -> SDA_T=1 asynchronously; after release, the next full transaction works.
